// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and default sizing for the data-memory arbiter
//                that sits between the core MEM stage, the debug/loader port
//                and the single-ported data RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Default number of 64-bit words in the shared data RAM.
  localparam int unsigned DMEM_WORDS_DEFAULT    = 1024;

  // Default number of consecutive lost cycles before the debug port wins.
  localparam int unsigned DMEM_MAX_WAIT_DEFAULT = 4;

  // Arbitration priority state.
  typedef enum logic [0:0] {
    CORE_PRI = 1'b0,   // core wins ties, debug starvation is being counted
    DBG_PRI  = 1'b1    // one-cycle window where debug wins ties
  } arb_state_e;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester arbiter for the shared 64-bit data RAM.
//                The core normally has priority; a debug requester that loses
//                MAX_WAIT consecutive cycles is given one cycle of priority.
//                Grant is combinational, read return is one cycle later and is
//                steered to the owner that issued it. Accesses whose address
//                exceeds the RAM are suppressed, flagged on err, and read as 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned WORDS    = DMEM_WORDS_DEFAULT,
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  // core MEM-stage requester
  input  logic                     c_req,
  input  logic                     c_we,
  input  logic [63:0]              c_addr,
  input  logic [63:0]              c_wdata,
  output logic                     c_stall,
  output logic                     c_rvalid,
  // debug / loader requester
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [63:0]              d_addr,
  input  logic [63:0]              d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  // shared read data
  output logic [63:0]              rdata,
  // RAM port
  output logic                     m_en,
  output logic                     m_we,
  output logic [$clog2(WORDS)-1:0] m_addr,
  output logic [63:0]              m_wdata,
  input  logic [63:0]              m_rdata,
  // out-of-range access flag
  output logic                     err
);

  // Word-index width and wait-counter width.
  localparam int unsigned   AW       = $clog2(WORDS);
  localparam int unsigned   CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

  // Registered state
  arb_state_e    state_q, state_d;
  logic [CW-1:0] wait_q,  wait_d;
  logic          c_rvalid_q;
  logic          d_rvalid_q;
  logic          rd_ok_q;     // pending read was in range, pass RAM data
  logic          err_q;

  // Combinational grant / datapath selection
  logic          w_core_gnt;
  logic          w_dbg_gnt;
  logic          w_any_gnt;
  logic          w_sel_we;
  logic [63:0]   w_sel_addr;
  logic [63:0]   w_sel_wdata;
  logic          w_in_range;
  logic          unused_addr_lsbs;

  // Grant decision from the current requests and the priority state; nothing
  // is granted while reset is held so the RAM and both requesters stay idle.
  always_comb begin
    w_core_gnt = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (!rst) begin
      if (state_q == CORE_PRI) begin
        w_core_gnt = c_req;
        w_dbg_gnt  = d_req & ~c_req;
      end else begin
        w_dbg_gnt  = d_req;
        w_core_gnt = c_req & ~d_req;
      end
    end
  end

  assign w_any_gnt   = w_core_gnt | w_dbg_gnt;
  assign w_sel_we    = w_dbg_gnt ? d_we    : c_we;
  assign w_sel_addr  = w_dbg_gnt ? d_addr  : c_addr;
  assign w_sel_wdata = w_dbg_gnt ? d_wdata : c_wdata;

  // Any set bit above the word index means the access falls outside the RAM.
  assign w_in_range  = ~|w_sel_addr[63:3+AW];

  // Byte offset within a word is ignored: all accesses are whole words.
  assign unused_addr_lsbs = ^w_sel_addr[2:0];

  // RAM port: enable only for a granted, in-range access.
  assign m_en    = w_any_gnt & w_in_range;
  assign m_we    = m_en & w_sel_we;
  assign m_addr  = w_sel_addr[3 +: AW];
  assign m_wdata = w_sel_wdata;

  // Requester-facing handshakes.
  assign c_stall  = c_req & ~w_core_gnt & ~rst;
  assign d_gnt    = w_dbg_gnt;
  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign err      = err_q;
  assign rdata    = rd_ok_q ? m_rdata : 64'h0;

  // Next priority state and debug starvation counter. In CORE_PRI the counter
  // tracks consecutive losses and saturates at MAX_WAIT, which hands priority
  // to debug for exactly one cycle before falling back to the core.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (state_q == CORE_PRI) begin
      if (d_req && !w_dbg_gnt) begin
        wait_d = (wait_q == WAIT_SAT) ? WAIT_SAT : wait_q + CW'(1);
      end else begin
        wait_d = '0;
      end
      if (wait_d == WAIT_SAT) begin
        state_d = DBG_PRI;
      end
    end else begin
      state_d = CORE_PRI;
      wait_d  = '0;
    end
  end

  // Arbiter FSM and registered return path: a read granted this cycle raises
  // exactly one owner's rvalid next cycle; a reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CORE_PRI;
      wait_q     <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      c_rvalid_q <= w_core_gnt & ~c_we;
      d_rvalid_q <= w_dbg_gnt & ~d_we;
      rd_ok_q    <= w_any_gnt & ~w_sel_we & w_in_range;
      err_q      <= w_any_gnt & ~w_in_range;
    end
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a small
//                behavioural RAM attached to the memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int unsigned WORDS = 1024;
  localparam int unsigned AW    = $clog2(WORDS);
  localparam logic [63:0] WORD0 = 64'hDEADBEEFCAFEBABE;

  logic          clk;
  logic          rst;
  logic          c_req, c_we;
  logic [63:0]   c_addr, c_wdata;
  logic          c_stall, c_rvalid;
  logic          d_req, d_we;
  logic [63:0]   d_addr, d_wdata;
  logic          d_gnt, d_rvalid;
  logic [63:0]   rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [63:0]   m_wdata;
  logic [63:0]   m_rdata;
  logic          err;

  int n_cmp;
  int n_bad;

  logic [63:0] mem [WORDS];

  dmem_arbiter #(.WORDS(WORDS), .MAX_WAIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_stall (c_stall),
    .c_rvalid(c_rvalid),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .rdata   (rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [63:0] ca,
                       input logic [63:0] cd, input logic dr, input logic dw,
                       input logic [63:0] da, input logic [63:0] dd);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h8, 64'h0);
    tick();
    tick();
    #1;
    n_cmp++; if (m_en !== 1'b0)     begin n_bad++; $display("FAIL rst_m_en got=%b exp=0", m_en); end
    n_cmp++; if (d_gnt !== 1'b0)    begin n_bad++; $display("FAIL rst_d_gnt got=%b exp=0", d_gnt); end
    n_cmp++; if (c_stall !== 1'b0)  begin n_bad++; $display("FAIL rst_c_stall got=%b exp=0", c_stall); end
    n_cmp++; if (c_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_c_rvalid got=%b exp=0", c_rvalid); end
    n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_d_rvalid got=%b exp=0", d_rvalid); end
    n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    idle();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_core_read();
    drive(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    #1;
    n_cmp++; if (m_en !== 1'b1)    begin n_bad++; $display("FAIL cr_m_en got=%b exp=1", m_en); end
    n_cmp++; if (m_we !== 1'b0)    begin n_bad++; $display("FAIL cr_m_we got=%b exp=0", m_we); end
    n_cmp++; if (m_addr !== '0)    begin n_bad++; $display("FAIL cr_m_addr got=%0d exp=0", m_addr); end
    n_cmp++; if (c_stall !== 1'b0) begin n_bad++; $display("FAIL cr_c_stall got=%b exp=0", c_stall); end
    tick();
    idle();
    #1;
    n_cmp++; if (c_rvalid !== 1'b1) begin n_bad++; $display("FAIL cr_c_rvalid got=%b exp=1", c_rvalid); end
    n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL cr_d_rvalid got=%b exp=0", d_rvalid); end
    n_cmp++; if (rdata !== WORD0)   begin n_bad++; $display("FAIL cr_rdata got=%h exp=%h", rdata, WORD0); end
    tick();
    #1;
    n_cmp++; if (c_rvalid !== 1'b0) begin n_bad++; $display("FAIL cr_rvalid_once got=%b exp=0", c_rvalid); end
  endtask

  task automatic test_dbg_write_core_read();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 64'h18, 64'h7FF);
    #1;
    n_cmp++; if (d_gnt !== 1'b1)       begin n_bad++; $display("FAIL dw_d_gnt got=%b exp=1", d_gnt); end
    n_cmp++; if (m_we !== 1'b1)        begin n_bad++; $display("FAIL dw_m_we got=%b exp=1", m_we); end
    n_cmp++; if (m_addr !== 10'd3)     begin n_bad++; $display("FAIL dw_m_addr got=%0d exp=3", m_addr); end
    n_cmp++; if (m_wdata !== 64'h7FF)  begin n_bad++; $display("FAIL dw_m_wdata got=%h exp=7ff", m_wdata); end
    tick();
    drive(1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    #1;
    n_cmp++; if (d_rvalid !== 1'b0)    begin n_bad++; $display("FAIL dw_no_rvalid got=%b exp=0", d_rvalid); end
    n_cmp++; if (m_addr !== 10'd3)     begin n_bad++; $display("FAIL cr18_m_addr got=%0d exp=3", m_addr); end
    n_cmp++; if (m_en !== 1'b1)        begin n_bad++; $display("FAIL cr18_m_en got=%b exp=1", m_en); end
    tick();
    idle();
    #1;
    n_cmp++; if (c_rvalid !== 1'b1)    begin n_bad++; $display("FAIL cr18_c_rvalid got=%b exp=1", c_rvalid); end
    n_cmp++; if (rdata !== 64'h7FF)    begin n_bad++; $display("FAIL cr18_rdata got=%h exp=7ff", rdata); end
    tick();
  endtask

  // Both requesters held: 4 core grants, 1 debug grant, repeating.
  task automatic test_starvation();
    logic prev_d;
    logic exp_d;
    prev_d = 1'b0;
    drive(1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0);
    for (int k = 1; k <= 11; k++) begin
      exp_d = ((k % 5) == 0);
      #1;
      n_cmp++; if (d_gnt !== exp_d)   begin n_bad++; $display("FAIL stv_d_gnt cyc=%0d got=%b exp=%b", k, d_gnt, exp_d); end
      n_cmp++; if (c_stall !== exp_d) begin n_bad++; $display("FAIL stv_c_stall cyc=%0d got=%b exp=%b", k, c_stall, exp_d); end
      if (k > 1) begin
        n_cmp++; if (d_rvalid !== prev_d)  begin n_bad++; $display("FAIL stv_d_rvalid cyc=%0d got=%b exp=%b", k, d_rvalid, prev_d); end
        n_cmp++; if (c_rvalid !== ~prev_d) begin n_bad++; $display("FAIL stv_c_rvalid cyc=%0d got=%b exp=%b", k, c_rvalid, ~prev_d); end
        n_cmp++; if (rdata !== (prev_d ? 64'h7FF : WORD0)) begin
          n_bad++; $display("FAIL stv_rdata cyc=%0d got=%h exp=%h", k, rdata, (prev_d ? 64'h7FF : WORD0));
        end
      end
      prev_d = exp_d;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 64'h2000, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    #1;
    n_cmp++; if (m_en !== 1'b0)    begin n_bad++; $display("FAIL oor_m_en got=%b exp=0", m_en); end
    n_cmp++; if (c_stall !== 1'b0) begin n_bad++; $display("FAIL oor_c_stall got=%b exp=0", c_stall); end
    n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL oor_err_early got=%b exp=0", err); end
    tick();
    idle();
    #1;
    n_cmp++; if (err !== 1'b1)      begin n_bad++; $display("FAIL oor_err got=%b exp=1", err); end
    n_cmp++; if (c_rvalid !== 1'b1) begin n_bad++; $display("FAIL oor_c_rvalid got=%b exp=1", c_rvalid); end
    n_cmp++; if (rdata !== 64'h0)   begin n_bad++; $display("FAIL oor_rdata got=%h exp=0", rdata); end
    tick();
    #1;
    n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL oor_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_reset_inflight();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0);
    #1;
    n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL rif_d_gnt got=%b exp=1", d_gnt); end
    @(posedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL rif_d_rvalid got=%b exp=0", d_rvalid); end
    n_cmp++; if (d_gnt !== 1'b0)    begin n_bad++; $display("FAIL rif_d_gnt_rst got=%b exp=0", d_gnt); end
    tick();
    n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL rif_d_rvalid2 got=%b exp=0", d_rvalid); end
    rst = 1'b0;
    drive(1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0);
    // Fresh CORE_PRI with zero count: debug must win on exactly the 5th cycle.
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_cmp++; if (d_gnt !== (k == 5)) begin n_bad++; $display("FAIL rif_post_d_gnt cyc=%0d got=%b exp=%b", k, d_gnt, (k == 5)); end
      if (k == 1) begin
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL rif_post_d_rvalid got=%b exp=0", d_rvalid); end
      end
      tick();
    end
    idle();
    tick();
  endtask

  // Single requester per cycle, alternating owners back to back.
  task automatic test_alternating();
    logic prev_d;
    logic cur_d;
    for (int k = 0; k <= 8; k++) begin
      cur_d = k[0];
      if (k < 8) begin
        if (cur_d) drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0);
        else       drive(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      end else begin
        idle();
      end
      #1;
      if (k > 0) begin
        n_cmp++; if (c_rvalid !== ~prev_d) begin n_bad++; $display("FAIL alt_c_rvalid cyc=%0d got=%b exp=%b", k, c_rvalid, ~prev_d); end
        n_cmp++; if (d_rvalid !== prev_d)  begin n_bad++; $display("FAIL alt_d_rvalid cyc=%0d got=%b exp=%b", k, d_rvalid, prev_d); end
        n_cmp++; if (rdata !== (prev_d ? 64'h7FF : WORD0)) begin
          n_bad++; $display("FAIL alt_rdata cyc=%0d got=%h exp=%h", k, rdata, (prev_d ? 64'h7FF : WORD0));
        end
      end
      prev_d = cur_d;
      tick();
    end
    #1;
    n_cmp++; if ((c_rvalid | d_rvalid) !== 1'b0) begin
      n_bad++; $display("FAIL alt_tail_rvalid got=%b%b exp=00", c_rvalid, d_rvalid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < int'(WORDS); i++) mem[i] = 64'h0;
    mem[0]  = WORD0;
    m_rdata = 64'h0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_core_read();
    test_dbg_write_core_read();
    test_starvation();
    test_out_of_range();
    test_reset_inflight();
    test_alternating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
